gpr_wb_sched: RTL
=================

GPR_WB_SCHED -- requirements
Module: gpr_wb_sched

Interface
REQ-001 SHALL have parameter NREQ, default 3, the number of writeback requesters (fixed at 3 in this revision).
REQ-002 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port wb_req[2:0], input, 3 bits: per-requester writeback valid.
REQ-005 SHALL have port wb_addr0/1/2, input, 5 bits each: destination GPR per requester.
REQ-006 SHALL have port wb_data0/1/2, input, 32 bits each: writeback data per requester.
REQ-007 SHALL have port wb_gnt[2:0], output, 3 bits: one-hot grant, combinational from wb_req and the pointer.
REQ-008 SHALL have ports wr_en, output, 1 bit; wr_addr, output, 5 bits; and wr_data, output, 32 bits: registered drive of the register-file write port.
REQ-009 SHALL have ports issue_en, input, 1 bit, and issue_addr, input, 5 bits: a dispatched instruction reserves destination GPR issue_addr.
REQ-010 SHALL have port issue_rdy, output, 1 bit: the destination may be reserved this cycle.
REQ-011 SHALL have ports rda_addr/rdb_addr/rdc_addr, input, 5 bits each: source operands to check.
REQ-012 SHALL have ports hz_a/hz_b/hz_c, output, 1 bit each: the matching source GPR is pending.
REQ-013 SHALL have port busy, output, 32 bits: scoreboard state, bit n means GPR n is pending.

Function
REQ-014 SHALL grant at most one requester per cycle, round-robin, starting from pointer ptr (0..2); wb_gnt = 0 when wb_req = 0.
REQ-015 SHALL check requesters in order ptr, ptr+1, ptr+2 (mod 3) and grant the first one asserting wb_req.
REQ-016 SHALL load ptr with (granted index + 1) mod 3 on each edge where a grant occurs; ptr SHALL hold otherwise.
REQ-017 A requester SHALL hold wb_req, address and data stable until granted; an ungranted request stays pending without loss.
REQ-018 SHALL, on an edge with a grant g, load wr_en=1, wr_addr=wb_addrg and wr_data=wb_datag; with no grant it SHALL load wr_en=0, and wr_addr/wr_data hold.
REQ-019 Latency: grant in cycle N, wr_en high in cycle N+1, GPR readable at the register-file output in cycle N+2.
REQ-020 SHALL set busy[issue_addr] on an edge where issue_en=1 and issue_rdy=1; issue_en with issue_rdy=0 SHALL be ignored.
REQ-021 SHALL clear busy[wr_addr] on every edge where wr_en=1.
REQ-022 issue_rdy = ~busy[issue_addr] | (wr_en & wr_addr==issue_addr), which forbids a WAW reservation.
REQ-023 Same edge set and clear of the same GPR SHALL leave busy set (set wins); different GPRs SHALL update independently.
REQ-024 hz_x = busy[rdx_addr] & ~(wr_en & wr_addr==rdx_addr), combinational, for each of ports a, b and c.
REQ-025 Writeback to a GPR that is not busy SHALL still write the GPR, and busy SHALL stay 0.

Reset
REQ-026 rst SHALL force ptr=0, wr_en=0, wr_addr=0, wr_data=0 and busy=0 immediately, independent of clk.
REQ-027 After reset issue_rdy=1 and hz_a/hz_b/hz_c=0 for any address; rst asserted mid-operation SHALL drop pending writes, and requesters re-request.

Verification
REQ-028 Reset, then wb_req=3'b111 held 3 cycles -> wb_gnt 001, 010, 100; wr_en high in cycles 2-4 with each requester's addr/data.
REQ-029 issue_en, issue_addr=5 -> busy[5]=1, hz_a=1 with rda_addr=5; req0 writes GPR5=0xDEADBEEF -> wr_en cycle: hz_a=0; next edge busy[5]=0.
REQ-030 busy[7]=1, issue_addr=7 with no write to GPR7 -> issue_rdy=0 and busy unchanged; same cycle wr_en with wr_addr=7 -> issue_rdy=1, and busy[7] stays 1 after the edge.
REQ-031 Only req2 asserted for 4 cycles with ptr=0 -> granted every cycle, ptr=0 afterwards, 4 consecutive wr_en pulses.
REQ-032 rst asserted while wr_en=1 and busy=0x0000_00F0 -> outputs and busy read 0 before the next clk edge.

Source files
------------

// File: rtl/gpr_wb_sched.sv
// GPR writeback scheduler: round-robin arbitration of three writeback requesters onto one
// register-file write port, plus a busy scoreboard for destination reservation and hazards.
module gpr_wb_sched #(
  parameter int unsigned NREQ = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] wb_req,
  input  logic [4:0]      wb_addr0,
  input  logic [4:0]      wb_addr1,
  input  logic [4:0]      wb_addr2,
  input  logic [31:0]     wb_data0,
  input  logic [31:0]     wb_data1,
  input  logic [31:0]     wb_data2,
  output logic [NREQ-1:0] wb_gnt,
  output logic            wr_en,
  output logic [4:0]      wr_addr,
  output logic [31:0]     wr_data,
  input  logic            issue_en,
  input  logic [4:0]      issue_addr,
  output logic            issue_rdy,
  input  logic [4:0]      rda_addr,
  input  logic [4:0]      rdb_addr,
  input  logic [4:0]      rdc_addr,
  output logic            hz_a,
  output logic            hz_b,
  output logic            hz_c,
  output logic [31:0]     busy
);

  logic [1:0]  ptr_q, ptr_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] busy_q, busy_d;

  logic        gnt_valid;
  logic [1:0]  gnt_idx;

  // Search order starts at ptr and wraps modulo 3.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    unique case (ptr_q)
      2'd1: begin
        if      (wb_req[1]) begin gnt_valid = 1'b1; gnt_idx = 2'd1; end
        else if (wb_req[2]) begin gnt_valid = 1'b1; gnt_idx = 2'd2; end
        else if (wb_req[0]) begin gnt_valid = 1'b1; gnt_idx = 2'd0; end
      end
      2'd2: begin
        if      (wb_req[2]) begin gnt_valid = 1'b1; gnt_idx = 2'd2; end
        else if (wb_req[0]) begin gnt_valid = 1'b1; gnt_idx = 2'd0; end
        else if (wb_req[1]) begin gnt_valid = 1'b1; gnt_idx = 2'd1; end
      end
      default: begin
        if      (wb_req[0]) begin gnt_valid = 1'b1; gnt_idx = 2'd0; end
        else if (wb_req[1]) begin gnt_valid = 1'b1; gnt_idx = 2'd1; end
        else if (wb_req[2]) begin gnt_valid = 1'b1; gnt_idx = 2'd2; end
      end
    endcase
  end

  always_comb begin
    wb_gnt = '0;
    if (gnt_valid) wb_gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d     = ptr_q;
    wr_en_d   = gnt_valid;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (gnt_valid) begin
      ptr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
      unique case (gnt_idx)
        2'd1:    begin wr_addr_d = wb_addr1; wr_data_d = wb_data1; end
        2'd2:    begin wr_addr_d = wb_addr2; wr_data_d = wb_data2; end
        default: begin wr_addr_d = wb_addr0; wr_data_d = wb_data0; end
      endcase
    end
  end

  // A write in flight frees its GPR this cycle, so reservation and hazard checks see it as free.
  assign issue_rdy = ~busy_q[issue_addr] | (wr_en_q & (wr_addr_q == issue_addr));
  assign hz_a      = busy_q[rda_addr] & ~(wr_en_q & (wr_addr_q == rda_addr));
  assign hz_b      = busy_q[rdb_addr] & ~(wr_en_q & (wr_addr_q == rdb_addr));
  assign hz_c      = busy_q[rdc_addr] & ~(wr_en_q & (wr_addr_q == rdc_addr));

  // Set is applied after clear so a same-GPR reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q)              busy_d[wr_addr_q]  = 1'b0;
    if (issue_en && issue_rdy) busy_d[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= 2'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= 32'd0;
      busy_q    <= 32'd0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule
